prio_encoder_rr: RTL and testbench

Parametrised, registered priority encoder for N active-low request lines, with sticky request capture, a valid/ready output handshake and a selectable fixed-priority or round-robin mode. It is the clocked successor to the 9-line combinational encoder. It sits between asynchronous-looking request strobes (interrupts, channel requests) and a single consumer that takes one encoded index per handshake. Short request pulses are never lost, and the output is held stable until accepted.

---
 rtl/prio_encoder_rr_pkg.sv | 24 ++
 rtl/prio_encoder_rr_if.sv | 33 +++
 rtl/prio_encoder_rr_pick.sv | 31 +++
 rtl/prio_encoder_rr.sv | 92 +++++++++
 tb/tb_prio_encoder_rr.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// Shared types and helpers for the registered priority encoder
// and for any arbiter that reuses its rotate-from-pointer search.
package prio_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int f_wrap_dec(input int k, input int n);
    return (k == 0) ? n - 1 : k - 1;
  endfunction

  function automatic logic [31:0] f_code_n(
    input int   idx,
    input logic valid,
    input int   cw
  );
    logic [31:0] m;
    m = (32'd1 << cw) - 32'd1;
    return valid ? (~(32'(idx) + 32'd1) & m) : m;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/handshake bundle between the request side, the encoder
// and the single consumer of encoded indices.
interface prio_encoder_rr_if #(
  parameter int N = 9
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  req_n;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_idx;
  logic [CW-1:0] out_code_n;
  logic [N-1:0]  pending;

  modport master (
    output req_n,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_code_n,
    input  pending
  );

  modport slave (
    input  req_n,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_code_n,
    output pending
  );
endinterface

// File: rtl/prio_encoder_rr_pick.sv
// First-set search over mask, starting at ptr and moving downward
// with wrap-around; the bit nearest below ptr (inclusive) wins.
module prio_pick #(
  parameter int N = 9,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  int best;
  int d;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    best = N;
    d    = 0;
    for (int j = 0; j < N; j++) begin
      d = (int'(ptr) - j + N) % N;
      if (mask[j] && d < best) begin
        best = d;
        idx  = W'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder: sticky capture of active-low requests,
// fixed or round-robin selection, held output until accepted.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter int N  = 9,
  parameter int RR = 0
) (
  input  logic             clk,
  input  logic             rst,
  prio_encoder_rr_if.slave bus
);

  localparam int W  = $clog2(N);
  localparam int CW = $clog2(N + 1);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   pend;
  logic [N-1:0]   pend_nxt;
  logic [N-1:0]   clr;
  logic [N-1:0]   mask;
  logic [W-1:0]   idx_q;
  logic [W-1:0]   idx_nxt;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_nxt;
  logic [W-1:0]   pick_idx;
  logic           pick_any;
  logic           hs;

  assign hs       = (state == HOLD) && bus.out_ready;
  assign clr      = hs ? (N'(1) << idx_q) : '0;
  assign mask     = pend & ~clr;
  // A line still held low re-arms on the very edge it is delivered.
  assign pend_nxt = mask | ~bus.req_n;

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .mask (mask),
    .ptr  (ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    unique case (state)
      EMPTY: begin
        if (pick_any) begin
          state_nxt = HOLD;
          idx_nxt   = pick_idx;
        end
      end
      HOLD: begin
        if (hs) begin
          if (pick_any) idx_nxt = pick_idx;
          else          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    ptr_nxt = ptr;
    if (RR != 0 && hs)
      ptr_nxt = W'(f_wrap_dec(int'(idx_q), N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      pend  <= '0;
      idx_q <= '0;
      ptr   <= W'(N - 1);
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      idx_q <= idx_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign bus.out_valid  = (state == HOLD);
  assign bus.out_idx    = idx_q;
  assign bus.pending    = pend;
  assign bus.out_code_n = CW'(f_code_n(int'(idx_q), state == HOLD, CW));

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed and round-robin instances side by side,
// directed sequences plus random traffic against a reference model.
module tb_prio_encoder_rr;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_n = '1;
  logic         rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  prio_encoder_rr_if #(.N(N)) bus0 ();
  prio_encoder_rr_if #(.N(N)) bus1 ();

  assign bus0.req_n     = req_n;
  assign bus0.out_ready = rdy;
  assign bus1.req_n     = req_n;
  assign bus1.out_ready = rdy;

  prio_encoder_rr #(.N(N), .RR(0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  prio_encoder_rr #(.N(N), .RR(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  logic [N-1:0] m_pend  [2];
  bit           m_valid [2];
  int           m_idx   [2];
  int           m_ptr   [2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = '0;
      m_valid[m] = 0;
      m_idx[m]   = 0;
      m_ptr[m]   = N - 1;
    end
  endtask

  // One rising edge of the behavioural model for mode m (0 fixed, 1 rr).
  task automatic model_step(input int m);
    logic [N-1:0] msk;
    bit           hs;
    bit           found;
    int           sel;
    int           j;
    hs    = m_valid[m] && rdy;
    msk   = m_pend[m];
    if (hs) msk[m_idx[m]] = 1'b0;
    found = 0;
    sel   = 0;
    for (int o = 0; o < N; o++) begin
      j = (m_ptr[m] - o + N) % N;
      if (!found && msk[j]) begin
        found = 1;
        sel   = j;
      end
    end
    if (hs && m == 1)
      m_ptr[m] = (m_idx[m] == 0) ? N - 1 : m_idx[m] - 1;
    if (!m_valid[m]) begin
      if (found) begin
        m_valid[m] = 1;
        m_idx[m]   = sel;
      end
    end else if (hs) begin
      if (found) m_idx[m] = sel;
      else       m_valid[m] = 0;
    end
    m_pend[m] = msk | ~req_n;
  endtask

  task automatic check_dut(
    input int         m,
    input logic       v,
    input logic [3:0] idx,
    input logic [3:0] code,
    input logic [8:0] pend
  );
    int ecode;
    ecode = m_valid[m] ? 14 - m_idx[m] : 15;
    chk($sformatf("m%0d_valid", m), int'(v), int'(m_valid[m]));
    chk($sformatf("m%0d_code_n", m), int'(code), ecode);
    chk($sformatf("m%0d_pending", m), int'(pend), int'(m_pend[m]));
    if (m_valid[m])
      chk($sformatf("m%0d_idx", m), int'(idx), m_idx[m]);
  endtask

  task automatic compare_all();
    check_dut(0, bus0.out_valid, bus0.out_idx, bus0.out_code_n, bus0.pending);
    check_dut(1, bus1.out_valid, bus1.out_idx, bus1.out_code_n, bus1.pending);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_n = '1;
    rdy   = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [8:0] req_n;
    logic       rdy;
    logic       valid;
    int         idx;
    logic [3:0] code;
    logic [8:0] pend;
  } vec_t;

  vec_t tbl [7];
  int   rr_exp [3];

  initial begin
    // pulse line 2, pulse line 8, hold without ready, then drain
    tbl[0] = '{9'h1FB, 1'b0, 1'b0, 0, 4'b1111, 9'h004};
    tbl[1] = '{9'h0FF, 1'b0, 1'b1, 2, 4'b1100, 9'h104};
    tbl[2] = '{9'h1FF, 1'b0, 1'b1, 2, 4'b1100, 9'h104};
    tbl[3] = '{9'h1FF, 1'b0, 1'b1, 2, 4'b1100, 9'h104};
    tbl[4] = '{9'h1FF, 1'b1, 1'b1, 8, 4'b0110, 9'h100};
    tbl[5] = '{9'h1FF, 1'b1, 1'b0, 0, 4'b1111, 9'h000};
    tbl[6] = '{9'h1FF, 1'b1, 1'b0, 0, 4'b1111, 9'h000};
    rr_exp = '{8, 4, 0};

    // reset and legacy fixed priority with line 7 held
    do_reset();
    chk("rst_idx", int'(bus0.out_idx), 0);
    req_n = 9'b1_0111_1111;
    rdy   = 1'b1;
    cycle();
    chk("legacy_edge1_valid", int'(bus0.out_valid), 0);
    cycle();
    chk("legacy_valid", int'(bus0.out_valid), 1);
    chk("legacy_idx", int'(bus0.out_idx), 7);
    chk("legacy_code", int'(bus0.out_code_n), 4'b0111);
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (bus0.out_valid) chk("legacy_repeat", int'(bus0.out_idx), 7);
    end

    // pulse capture and hold, table-driven
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req_n = tbl[i].req_n;
      rdy   = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_fp_valid", i), int'(bus0.out_valid), int'(tbl[i].valid));
      chk($sformatf("tbl%0d_fp_code", i), int'(bus0.out_code_n), int'(tbl[i].code));
      chk($sformatf("tbl%0d_fp_pend", i), int'(bus0.pending), int'(tbl[i].pend));
      chk($sformatf("tbl%0d_rr_valid", i), int'(bus1.out_valid), int'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_fp_idx", i), int'(bus0.out_idx), tbl[i].idx);
        chk($sformatf("tbl%0d_rr_idx", i), int'(bus1.out_idx), tbl[i].idx);
      end
    end

    // fixed priority drain of all nine lines
    do_reset();
    req_n = '0;
    rdy   = 1'b1;
    cycle();
    req_n = '1;
    for (int k = 0; k < N; k++) begin
      cycle();
      chk("drain_fp_idx", int'(bus0.out_idx), 8 - k);
      chk("drain_rr_idx", int'(bus1.out_idx), 8 - k);
      chk("drain_valid", int'(bus0.out_valid), 1);
    end
    cycle();
    chk("drain_empty", int'(bus0.out_valid), 0);
    chk("drain_empty_code", int'(bus0.out_code_n), 4'b1111);

    // round-robin fairness, lines 8, 4, 0 held
    do_reset();
    req_n = ~9'h111;
    rdy   = 1'b1;
    cycle();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_fair_valid", int'(bus1.out_valid), 1);
      chk("rr_fair_idx", int'(bus1.out_idx), rr_exp[k % 3]);
    end

    // round-robin wrap after granting line 0
    do_reset();
    req_n = ~9'h001;
    cycle();
    req_n = '1;
    cycle();
    chk("wrap_first_idx", int'(bus1.out_idx), 0);
    rdy   = 1'b1;
    req_n = ~9'h101;
    cycle();
    req_n = '1;
    rdy   = 1'b0;
    cycle();
    chk("wrap_valid", int'(bus1.out_valid), 1);
    chk("wrap_idx", int'(bus1.out_idx), 8);

    // asynchronous reset while holding
    req_n = ~9'h008;
    cycle();
    req_n = '1;
    cycle();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", int'(bus0.out_valid), 0);
    chk("arst_pend", int'(bus0.pending), 0);
    chk("arst_code", int'(bus0.out_code_n), 4'b1111);
    chk("arst_rr_valid", int'(bus1.out_valid), 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_n = ~9'h020;
    cycle();
    req_n = '1;
    chk("arst_edge1_valid", int'(bus0.out_valid), 0);
    cycle();
    chk("arst_re_valid", int'(bus0.out_valid), 1);
    chk("arst_re_idx", int'(bus0.out_idx), 5);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        req_n[b] = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
